ifmap_read_sequencer: RTL

IFMAP_READ_SEQUENCER -- requirements
Module: ifmap_read_sequencer

---
 rtl/ifmap_pkg.sv | 46 ++++
 rtl/ifmap_skid_fifo.sv | 73 +++++++
 rtl/ifmap_read_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ifmap_pkg.sv
// Shared types and sizes for the ifmap read sequencer.
// Define IFMAP_SEQ_PAD_EN to add the PRE_PAD/POST_PAD states used for zero padding.
package ifmap_pkg;

  localparam int unsigned IFMAP_DEPTH = 128;
  localparam int unsigned IFMAP_AW    = 7;
  localparam int unsigned ACT_W       = 8;
  localparam int unsigned LEN_W       = 8;
  localparam int unsigned PAD_W       = 2;
  localparam int unsigned FIFO_W      = ACT_W + 1;

  typedef logic signed [ACT_W-1:0] act_t;

  // One FIFO entry: activation plus its end-of-sequence marker
  typedef struct packed {
    logic last;
    act_t data;
  } act_entry_t;

`ifdef IFMAP_SEQ_PAD_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_PAD  = 3'd1,
    RUN      = 3'd2,
    POST_PAD = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;
`endif

  // Requests longer than the buffer are limited to one full pass
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req_len);
    if (req_len > LEN_W'(IFMAP_DEPTH)) begin
      return LEN_W'(IFMAP_DEPTH);
    end
    return req_len;
  endfunction

endpackage

// File: rtl/ifmap_skid_fifo.sv
// Two-entry output FIFO for the activation stream; head entry is registered so
// data/last stay stable while the consumer stalls.
module ifmap_skid_fifo
  import ifmap_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_push,
  input  act_entry_t i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output act_entry_t o_head,
  output logic [1:0] o_count
);

  logic [1:0] r_cnt;
  logic       r_vld;
  act_entry_t r_q0;
  act_entry_t r_q1;

  logic       w_pop;
  logic       w_push;
  logic [1:0] w_cnt_nxt;

  assign w_pop  = i_pop & r_vld;
  // A push into a full FIFO with no pop is refused rather than corrupting order
  assign w_push = i_push & ((r_cnt != 2'd2) | w_pop);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 2'd0;
      r_vld <= 1'b0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_vld <= (w_cnt_nxt != 2'd0);
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_q0 <= i_data;
          end else begin
            r_q1 <= i_data;
          end
        end
        2'b01: r_q0 <= r_q1;
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= i_data;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = r_vld;
  assign o_head  = r_q0;
  assign o_count = r_cnt;

endmodule

// File: rtl/ifmap_read_sequencer.sv
// Streams a run of ifmap buffer samples to the ternary PE array.
// Define IFMAP_SEQ_PAD_EN to add the pad port and leading/trailing zero samples.
module ifmap_read_sequencer
  import ifmap_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [IFMAP_AW-1:0]     base_addr,
  input  logic [LEN_W-1:0]        len,
`ifdef IFMAP_SEQ_PAD_EN
  input  logic [PAD_W-1:0]        pad,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    sram_enable,
  output logic                    sram_wr_en,
  output logic [IFMAP_AW-1:0]     sram_addr,
  input  logic signed [ACT_W-1:0] sram_rdata,
  output logic                    act_valid,
  input  logic                    act_ready,
  output logic signed [ACT_W-1:0] act_data,
  output logic                    act_last
);

  seq_state_t          r_state;
  logic                r_busy;
  logic                r_done;
  logic [IFMAP_AW-1:0] r_addr;
  logic [LEN_W-1:0]    r_rd_left;
  logic                r_pend;
  logic                r_pend_last;
`ifdef IFMAP_SEQ_PAD_EN
  logic [PAD_W-1:0]    r_pad;
  logic [PAD_W-1:0]    r_pad_left;
`endif

  logic                w_pop;
  logic [2:0]          w_room;
  logic                w_issue;
  logic                w_issue_last;
  logic                w_pad_push;
  logic                w_pad_last;
  logic                w_push;
  act_entry_t          w_push_data;
  logic                w_fifo_valid;
  act_entry_t          w_fifo_head;
  logic [1:0]          w_fifo_cnt;

  assign w_pop = w_fifo_valid & act_ready;

  // Occupancy after this cycle's pop plus the read whose data lands this cycle;
  // using the live handshake lets a read issue every cycle while the sink keeps up.
  assign w_room       = 3'(w_fifo_cnt) + 3'(r_pend) - 3'(w_pop);
  assign w_issue      = (r_state == RUN) && (w_room < 3'd2);
  assign w_issue_last = w_issue && (r_rd_left == LEN_W'(1));

`ifdef IFMAP_SEQ_PAD_EN
  // Zero samples share the FIFO's single push port, so they wait out any SRAM data
  assign w_pad_push = ((r_state == PRE_PAD) || (r_state == POST_PAD)) && !r_pend
                      && (w_room < 3'd2);
  assign w_pad_last = (r_state == POST_PAD) && (r_pad_left == PAD_W'(1));
`else
  assign w_pad_push = 1'b0;
  assign w_pad_last = 1'b0;
`endif

  assign w_push = r_pend | w_pad_push;

  always_comb begin
    w_push_data = '0;
    if (r_pend) begin
      w_push_data.last = r_pend_last;
      w_push_data.data = sram_rdata;
    end else begin
      w_push_data.last = w_pad_last;
    end
  end

  // Sequencer state, counters and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_rd_left   <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
`ifdef IFMAP_SEQ_PAD_EN
      r_pad       <= '0;
      r_pad_left  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_pend <= w_issue;
`ifdef IFMAP_SEQ_PAD_EN
      r_pend_last <= w_issue_last && (r_pad == '0);
`else
      r_pend_last <= w_issue_last;
`endif
      if (w_issue) begin
        r_addr    <= r_addr + IFMAP_AW'(1);
        r_rd_left <= r_rd_left - LEN_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr    <= base_addr;
            r_rd_left <= clamp_len(len);
            if (len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_busy <= 1'b1;
`ifdef IFMAP_SEQ_PAD_EN
              r_pad      <= pad;
              r_pad_left <= pad;
              r_state    <= (pad != '0) ? PRE_PAD : RUN;
`else
              r_state <= RUN;
`endif
            end
          end
        end
`ifdef IFMAP_SEQ_PAD_EN
        PRE_PAD: begin
          if (w_pad_push) begin
            r_pad_left <= r_pad_left - PAD_W'(1);
            if (r_pad_left == PAD_W'(1)) begin
              r_pad_left <= r_pad;
              r_state    <= RUN;
            end
          end
        end
        RUN: begin
          if (w_issue_last) begin
            r_state <= (r_pad != '0) ? POST_PAD : DRAIN;
          end
        end
        POST_PAD: begin
          if (w_pad_push) begin
            r_pad_left <= r_pad_left - PAD_W'(1);
            if (r_pad_left == PAD_W'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
`else
        RUN: begin
          if (w_issue_last) begin
            r_state <= DRAIN;
          end
        end
`endif
        DRAIN: begin
          if (w_pop && w_fifo_head.last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  ifmap_skid_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_cnt)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign sram_enable = ~w_issue;
  assign sram_wr_en  = 1'b1;
  assign sram_addr   = r_addr;
  assign act_valid   = w_fifo_valid;
  assign act_data    = w_fifo_head.data;
  assign act_last    = w_fifo_head.last;

endmodule
